// File: rtl/cart_dac_pkg.sv
// Shared register map, control/status bit positions and mix sizing for the
// cartridge DAC block.
package cart_dac_pkg;

    localparam logic [3:0] SAMPLE_BASE = 4'h0;
    localparam logic [3:0] CTRL        = 4'h8;
    localparam logic [3:0] DIV_LO      = 4'h9;
    localparam logic [3:0] DIV_HI      = 4'hA;
    localparam logic [3:0] STATUS      = 4'hF;

    localparam int CTRL_FIFO_MODE = 0;
    localparam int CTRL_IRQ_EN    = 1;
    localparam int CTRL_FLUSH     = 2;

    localparam int ST_EMPTY = 0;
    localparam int ST_FULL  = 1;
    localparam int ST_OVF   = 2;
    localparam int ST_UNF   = 3;
    localparam int ST_IRQ   = 4;

    // Width of one side's sample sum before MSB-alignment into the mix output.
    function automatic int mix_sum_w(input int sample_w, input int channels);
        return sample_w + $clog2(channels / 2);
    endfunction

endpackage

// File: rtl/cart_dac_fifo_if.sv
// CPU-side bus of the cart DAC: phase enable, select, direction, address and data.
interface cart_dac_fifo_if;
    logic       pclk0;
    logic       cs;
    logic       rw;
    logic [3:0] address;
    logic [7:0] din;
    logic [7:0] dout;

    modport master (output pclk0, cs, rw, address, din, input dout);
    modport slave  (input pclk0, cs, rw, address, din, output dout);
endinterface

// File: rtl/dac_sample_fifo.sv
// Per-channel sample FIFO; a pop on a full FIFO frees the slot a coincident push uses.
module dac_sample_fifo #(
    parameter int DEPTH    = 16,
    parameter int SAMPLE_W = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [SAMPLE_W-1:0]      data_in,
    output logic [SAMPLE_W-1:0]      data_out,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);
    localparam int AW = $clog2(DEPTH);

    logic [SAMPLE_W-1:0] mem [DEPTH];
    logic [AW-1:0]       wr_ptr;
    logic [AW-1:0]       rd_ptr;
    logic                do_push;
    logic                do_pop;

    assign empty    = (count == '0);
    assign full     = (count == (AW+1)'(DEPTH));
    assign do_pop   = pop & ~empty;
    assign do_push  = push & (~full | do_pop);
    assign data_out = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push & ~flush) mem[wr_ptr] <= data_in;
    end

endmodule

// File: rtl/cart_dac_fifo.sv
// Multi-channel cart DAC: register file, rate timer, per-channel FIFOs,
// sticky status, refill IRQ and the registered stereo mixer.
module cart_dac_fifo
    import cart_dac_pkg::*;
#(
    parameter int CHANNELS = 4,
    parameter int DEPTH    = 16,
    parameter int SAMPLE_W = 8,
    parameter int MIX_W    = 16
) (
    input  logic               clk_sys,
    input  logic               reset,
    cart_dac_fifo_if.slave     bus,
    output logic               irq_n,
    output logic [MIX_W-1:0]   audio_r,
    output logic [MIX_W-1:0]   audio_l
);
    localparam int HALF  = CHANNELS / 2;
    localparam int SUM_W = mix_sum_w(SAMPLE_W, CHANNELS);
    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam int CH_W  = $clog2(CHANNELS);
    localparam logic [3:0] NCH = 4'(CHANNELS);

    logic        fifo_mode, irq_en;
    logic [15:0] div, counter;
    logic        ovf, unf;

    logic        wr, status_rd, sample_wr, ctrl_wr, div_lo_wr, div_hi_wr;
    logic        flush, tick, pop_all, irq_pend;
    logic        ovf_set, unf_set;

    logic [CHANNELS-1:0]               push, full, empty, low;
    logic [CHANNELS-1:0][SAMPLE_W-1:0] head, smp;
    logic [CHANNELS-1:0][CNT_W-1:0]    count;
    logic [SUM_W-1:0]                  sum_r, sum_l;
    logic [7:0]                        status;

    assign wr        = bus.cs & ~bus.rw & bus.pclk0;
    assign status_rd = bus.cs & bus.rw & bus.pclk0 & (bus.address == STATUS);
    assign sample_wr = wr & (bus.address < NCH);
    assign ctrl_wr   = wr & (bus.address == CTRL);
    assign div_lo_wr = wr & (bus.address == DIV_LO);
    assign div_hi_wr = wr & (bus.address == DIV_HI);

    // Any mode change discards queued samples so stale data never plays.
    assign flush   = ctrl_wr & (bus.din[CTRL_FLUSH] | (bus.din[CTRL_FIFO_MODE] != fifo_mode));
    assign tick    = bus.pclk0 & fifo_mode & (counter == '0);
    assign pop_all = tick & ~flush;

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            fifo_mode <= 1'b0;
            irq_en    <= 1'b0;
            div       <= '0;
        end else begin
            if (ctrl_wr) begin
                fifo_mode <= bus.din[CTRL_FIFO_MODE];
                irq_en    <= bus.din[CTRL_IRQ_EN];
            end
            if (div_lo_wr) div[7:0]  <= bus.din;
            if (div_hi_wr) div[15:8] <= bus.din;
        end
    end

    // Reload on DIV write takes priority; DIV=0 naturally yields a tick per pclk0.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset)                        counter <= '0;
        else if (div_lo_wr)               counter <= {div[15:8], bus.din};
        else if (div_hi_wr)               counter <= {bus.din, div[7:0]};
        else if (bus.pclk0 & fifo_mode)   counter <= (counter == '0) ? div : counter - 1'b1;
    end

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        assign push[c] = sample_wr & fifo_mode & (bus.address == 4'(c));
        assign low[c]  = (count[c] <= CNT_W'(DEPTH / 2));

        dac_sample_fifo #(.DEPTH(DEPTH), .SAMPLE_W(SAMPLE_W)) u_fifo (
            .clk      (clk_sys),
            .rst      (reset),
            .push     (push[c]),
            .pop      (pop_all),
            .flush    (flush),
            .data_in  (bus.din[SAMPLE_W-1:0]),
            .data_out (head[c]),
            .count    (count[c]),
            .full     (full[c]),
            .empty    (empty[c])
        );
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            smp <= '0;
        end else begin
            for (int c = 0; c < CHANNELS; c++) begin
                if (sample_wr & ~fifo_mode & (bus.address == 4'(c))) smp[c] <= bus.din[SAMPLE_W-1:0];
                else if (pop_all & ~empty[c])                        smp[c] <= head[c];
            end
        end
    end

    assign ovf_set  = |(push & full) & ~pop_all;
    assign unf_set  = pop_all & |empty;
    assign irq_pend = irq_en & fifo_mode & |low;

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            ovf   <= 1'b0;
            unf   <= 1'b0;
            irq_n <= 1'b1;
        end else begin
            ovf   <= (ovf & ~status_rd) | ovf_set;
            unf   <= (unf & ~status_rd) | unf_set;
            irq_n <= ~irq_pend;
        end
    end

    always_comb begin
        sum_r = '0;
        sum_l = '0;
        for (int c = 0; c < HALF; c++) begin
            sum_r = sum_r + SUM_W'(smp[c]);
            sum_l = sum_l + SUM_W'(smp[c + HALF]);
        end
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            audio_r <= '0;
            audio_l <= '0;
        end else begin
            audio_r <= MIX_W'(sum_r) << (MIX_W - SUM_W);
            audio_l <= MIX_W'(sum_l) << (MIX_W - SUM_W);
        end
    end

    always_comb begin
        status           = '0;
        status[ST_EMPTY] = |empty;
        status[ST_FULL]  = |full;
        status[ST_OVF]   = ovf;
        status[ST_UNF]   = unf;
        status[ST_IRQ]   = irq_pend;
    end

    always_comb begin
        bus.dout = '0;
        case (bus.address)
            CTRL:    bus.dout = {6'd0, irq_en, fifo_mode};
            DIV_LO:  bus.dout = div[7:0];
            DIV_HI:  bus.dout = div[15:8];
            STATUS:  bus.dout = status;
            default: if (bus.address < NCH) bus.dout = 8'(smp[bus.address[CH_W-1:0]]);
        endcase
    end

endmodule

// File: tb/tb_cart_dac_fifo.sv
// Directed bench for cart_dac_fifo (4 channels, depth 16, 8-bit samples, 16-bit mix).
module tb_cart_dac_fifo;
    import cart_dac_pkg::*;

    logic        clk_sys = 1'b0;
    logic        reset;
    logic        irq_n;
    logic [15:0] audio_r, audio_l;
    int          vectors = 0;
    int          miscompares = 0;

    cart_dac_fifo_if bus();

    cart_dac_fifo #(.CHANNELS(4), .DEPTH(16), .SAMPLE_W(8), .MIX_W(16)) dut (
        .clk_sys (clk_sys),
        .reset   (reset),
        .bus     (bus),
        .irq_n   (irq_n),
        .audio_r (audio_r),
        .audio_l (audio_l)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic bus_idle(input int n, input logic p);
        for (int i = 0; i < n; i++) begin
            bus.cs = 1'b0; bus.pclk0 = p;
            @(posedge clk_sys); #1;
        end
        bus.pclk0 = 1'b0;
    endtask

    task automatic bus_write(input logic [3:0] a, input logic [7:0] d);
        bus.cs = 1'b1; bus.rw = 1'b0; bus.address = a; bus.din = d; bus.pclk0 = 1'b1;
        @(posedge clk_sys); #1;
        bus.cs = 1'b0; bus.rw = 1'b1; bus.pclk0 = 1'b0;
    endtask

    task automatic bus_read(input logic [3:0] a, input logic p, output logic [7:0] d);
        bus.cs = 1'b1; bus.rw = 1'b1; bus.address = a; bus.pclk0 = p;
        #2 d = bus.dout;
        @(posedge clk_sys); #1;
        bus.cs = 1'b0; bus.pclk0 = 1'b0;
    endtask

    task automatic test_reset();
        logic [7:0] d;
        vectors++; if (audio_r !== 16'h0) begin miscompares++; $display("FAIL reset_audio_r got=%h exp=0000", audio_r); end
        vectors++; if (audio_l !== 16'h0) begin miscompares++; $display("FAIL reset_audio_l got=%h exp=0000", audio_l); end
        vectors++; if (irq_n !== 1'b1) begin miscompares++; $display("FAIL reset_irq_n got=%b exp=1", irq_n); end
        bus_read(STATUS, 1'b0, d);
        vectors++; if (d !== 8'h01) begin miscompares++; $display("FAIL reset_status got=%h exp=01", d); end
        bus_read(4'h0, 1'b0, d);
        vectors++; if (d !== 8'h00) begin miscompares++; $display("FAIL reset_sample0 got=%h exp=00", d); end
    endtask

    task automatic test_direct();
        logic [7:0] d;
        bus_write(4'h0, 8'h80);
        bus_write(4'h1, 8'h40);
        bus_write(4'h2, 8'h10);
        bus_write(4'h3, 8'h20);
        vectors++; if (audio_l !== 16'h0800) begin miscompares++; $display("FAIL direct_latency_l got=%h exp=0800", audio_l); end
        bus_idle(1, 1'b0);
        vectors++; if (audio_r !== 16'h6000) begin miscompares++; $display("FAIL direct_audio_r got=%h exp=6000", audio_r); end
        vectors++; if (audio_l !== 16'h1800) begin miscompares++; $display("FAIL direct_audio_l got=%h exp=1800", audio_l); end
        bus_read(4'h2, 1'b0, d);
        vectors++; if (d !== 8'h10) begin miscompares++; $display("FAIL direct_readback got=%h exp=10", d); end
    endtask

    task automatic test_fifo_rate();
        logic [7:0] d;
        logic [7:0] exp_seq [5] = '{8'h11, 8'h11, 8'h22, 8'h33, 8'h33};
        int         pulses  [5] = '{1, 3, 1, 4, 4};
        bus_write(DIV_LO, 8'h03);
        bus_write(CTRL, 8'h01);
        bus_write(4'h0, 8'h11);
        bus_write(4'h0, 8'h22);
        bus_write(4'h0, 8'h33);
        bus_read(4'h0, 1'b0, d);
        vectors++; if (d !== 8'h80) begin miscompares++; $display("FAIL fifo_no_direct_load got=%h exp=80", d); end
        for (int k = 0; k < 5; k++) begin
            bus_idle(pulses[k], 1'b1);
            bus_read(4'h0, 1'b0, d);
            vectors++; if (d !== exp_seq[k]) begin miscompares++; $display("FAIL fifo_step%0d got=%h exp=%h", k, d, exp_seq[k]); end
        end
        vectors++; if (audio_r !== 16'h3980) begin miscompares++; $display("FAIL fifo_audio_r got=%h exp=3980", audio_r); end
        bus_write(DIV_HI, 8'hFF);
        bus_read(STATUS, 1'b0, d);
        vectors++; if (d !== 8'h09) begin miscompares++; $display("FAIL underflow_peek got=%h exp=09", d); end
        bus_read(STATUS, 1'b1, d);
        vectors++; if (d !== 8'h09) begin miscompares++; $display("FAIL underflow_read got=%h exp=09", d); end
        bus_read(STATUS, 1'b0, d);
        vectors++; if (d !== 8'h01) begin miscompares++; $display("FAIL status_cleared got=%h exp=01", d); end
    endtask

    task automatic test_overflow();
        logic [7:0] d;
        for (int i = 0; i < 16; i++) bus_write(4'h1, 8'hA0 + 8'(i));
        bus_read(STATUS, 1'b0, d);
        vectors++; if (d !== 8'h03) begin miscompares++; $display("FAIL full_status got=%h exp=03", d); end
        bus_write(4'h1, 8'hB0);
        bus_read(STATUS, 1'b0, d);
        vectors++; if (d !== 8'h07) begin miscompares++; $display("FAIL overflow_status got=%h exp=07", d); end
        bus_write(DIV_HI, 8'h00);
        bus_write(DIV_LO, 8'h00);
        for (int i = 0; i < 16; i++) begin
            bus_idle(1, 1'b1);
            bus_read(4'h1, 1'b0, d);
            vectors++; if (d !== 8'hA0 + 8'(i)) begin miscompares++; $display("FAIL drain%0d got=%h exp=%h", i, d, 8'hA0 + 8'(i)); end
        end
        bus_idle(1, 1'b1);
        bus_read(4'h1, 1'b0, d);
        vectors++; if (d !== 8'hAF) begin miscompares++; $display("FAIL drain_hold got=%h exp=af", d); end
        bus_read(STATUS, 1'b0, d);
        vectors++; if (d !== 8'h0D) begin miscompares++; $display("FAIL drain_status got=%h exp=0d", d); end
    endtask

    task automatic test_irq();
        logic [7:0] d;
        bus_write(DIV_HI, 8'hFF);
        bus_read(STATUS, 1'b1, d);
        bus_write(CTRL, 8'h03);
        bus_idle(1, 1'b0);
        vectors++; if (irq_n !== 1'b0) begin miscompares++; $display("FAIL irq_empty got=%b exp=0", irq_n); end
        for (int c = 0; c < 4; c++)
            for (int i = 0; i < 16; i++) bus_write(4'(c), 8'((c << 4) | i));
        bus_idle(1, 1'b0);
        vectors++; if (irq_n !== 1'b1) begin miscompares++; $display("FAIL irq_full got=%b exp=1", irq_n); end
        bus_read(STATUS, 1'b0, d);
        vectors++; if (d !== 8'h02) begin miscompares++; $display("FAIL irq_full_status got=%h exp=02", d); end
        bus_write(DIV_HI, 8'h00);
        bus_idle(7, 1'b1);
        bus_idle(2, 1'b0);
        vectors++; if (irq_n !== 1'b1) begin miscompares++; $display("FAIL irq_count9 got=%b exp=1", irq_n); end
        bus_idle(1, 1'b1);
        vectors++; if (irq_n !== 1'b1) begin miscompares++; $display("FAIL irq_lag got=%b exp=1", irq_n); end
        bus_idle(1, 1'b0);
        vectors++; if (irq_n !== 1'b0) begin miscompares++; $display("FAIL irq_count8 got=%b exp=0", irq_n); end
        bus_read(4'h0, 1'b0, d);
        vectors++; if (d !== 8'h07) begin miscompares++; $display("FAIL irq_out0 got=%h exp=07", d); end
        bus_read(STATUS, 1'b0, d);
        vectors++; if (d !== 8'h10) begin miscompares++; $display("FAIL irq_status got=%h exp=10", d); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] d;
        bus_write(DIV_HI, 8'hFF);
        bus_write(CTRL, 8'h05);
        for (int i = 0; i < 16; i++) bus_write(4'h0, 8'h50 + 8'(i));
        bus_read(STATUS, 1'b1, d);
        bus_read(STATUS, 1'b0, d);
        vectors++; if (d !== 8'h03) begin miscompares++; $display("FAIL b2b_pre_status got=%h exp=03", d); end
        bus_write(DIV_HI, 8'h00);
        bus_write(4'h0, 8'h77);
        bus_read(STATUS, 1'b0, d);
        vectors++; if (d !== 8'h0B) begin miscompares++; $display("FAIL b2b_status got=%h exp=0b", d); end
        bus_read(4'h0, 1'b0, d);
        vectors++; if (d !== 8'h50) begin miscompares++; $display("FAIL b2b_out0 got=%h exp=50", d); end
        bus_write(CTRL, 8'h05);
        bus_read(STATUS, 1'b0, d);
        vectors++; if (d !== 8'h09) begin miscompares++; $display("FAIL flush_status got=%h exp=09", d); end
        bus_read(4'h0, 1'b0, d);
        vectors++; if (d !== 8'h50) begin miscompares++; $display("FAIL flush_out0 got=%h exp=50", d); end
        bus_read(4'h1, 1'b0, d);
        vectors++; if (d !== 8'h18) begin miscompares++; $display("FAIL flush_out1 got=%h exp=18", d); end
    endtask

    task automatic test_reset_mid();
        logic [7:0] d;
        bus_write(DIV_HI, 8'hFF);
        bus_write(CTRL, 8'h03);
        for (int i = 0; i < 4; i++) bus_write(4'h0, 8'h61 + 8'(i));
        bus_write(4'h2, 8'h71);
        bus_write(4'h2, 8'h72);
        bus_idle(1, 1'b0);
        vectors++; if (irq_n !== 1'b0) begin miscompares++; $display("FAIL mid_irq got=%b exp=0", irq_n); end
        vectors++; if (audio_r !== 16'h3400) begin miscompares++; $display("FAIL mid_audio_r got=%h exp=3400", audio_r); end
        vectors++; if (audio_l !== 16'h3000) begin miscompares++; $display("FAIL mid_audio_l got=%h exp=3000", audio_l); end
        bus.address = STATUS;
        #3 reset = 1'b1;
        #1;
        vectors++; if (audio_r !== 16'h0) begin miscompares++; $display("FAIL rst_audio_r got=%h exp=0000", audio_r); end
        vectors++; if (audio_l !== 16'h0) begin miscompares++; $display("FAIL rst_audio_l got=%h exp=0000", audio_l); end
        vectors++; if (irq_n !== 1'b1) begin miscompares++; $display("FAIL rst_irq_n got=%b exp=1", irq_n); end
        vectors++; if (bus.dout !== 8'h01) begin miscompares++; $display("FAIL rst_status got=%h exp=01", bus.dout); end
        @(posedge clk_sys); #1 reset = 1'b0;
        bus_idle(1, 1'b1);
        bus_read(4'h0, 1'b0, d);
        vectors++; if (d !== 8'h00) begin miscompares++; $display("FAIL rst_out0 got=%h exp=00", d); end
        bus_read(STATUS, 1'b0, d);
        vectors++; if (d !== 8'h01) begin miscompares++; $display("FAIL rst_post_status got=%h exp=01", d); end
    endtask

    initial begin
        reset = 1'b1;
        bus.pclk0 = 1'b0; bus.cs = 1'b0; bus.rw = 1'b1; bus.address = 4'h0; bus.din = 8'h00;
        repeat (3) @(posedge clk_sys);
        #1 reset = 1'b0;
        test_reset();
        test_direct();
        test_fifo_rate();
        test_overflow();
        test_irq();
        test_back_to_back();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
